// File: rtl/apb_reg_slave_if.sv
// ---------------------------------------------------------------------------
// apb_reg_slave_if
//   APB bus bundle between one interconnect port and one register completer.
//
//   Parameters : ADDR_W  - paddr width
//                DATA_W  - pwdata/prdata width
//   Signals    : psel, penable, pwrite, paddr, pwdata  (requester -> completer)
//                pready, prdata, pslverr               (completer -> requester)
//   Modports   : master - drives the request side, observes the response
//                slave  - observes the request side, drives the response
// ---------------------------------------------------------------------------
interface apb_reg_slave_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
//   APB completer holding NUM_REGS 32-bit registers. Registers 0..NUM_REGS-2
//   are read/write (reset 0); register NUM_REGS-1 is a read-only ID register.
//   Bad offsets and writes to the ID register complete with pslverr=1.
//
//   Ports : clk  - clock, all state on the rising edge
//           rst  - asynchronous, active-high reset
//           bus  - apb_reg_slave_if.slave (psel, penable, pwrite, paddr,
//                  pwdata in; pready, prdata, pslverr out)
//
//   Optional feature macro: APB_SLV_WAIT_EN
//     defined   - WAIT_CYCLES wait states are inserted in every transfer
//     undefined - zero-wait; pready in the first ACCESS cycle, no counter
// ---------------------------------------------------------------------------
module apb_reg_slave #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int OFFSET_W    = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  apb_reg_slave_if.slave     bus
);

  localparam int IDX_W = OFFSET_W - 2;
  localparam logic [DATA_W-1:0] ID_VAL = DATA_W'(32'hA5B0_0000 | 32'(NUM_REGS));

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] regs [NUM_REGS-1];

  logic              setup;
  logic              ready;
  logic              commit;
  logic              bad_idx;
  logic              ro_wr;
  logic              err;
  logic [31:0]       idx_ext;
  logic [DATA_W-1:0] rd_val;

  // Byte-lane bits and the bits already decoded by the interconnect are
  // intentionally not looked at.
  logic unused_paddr_bits;
  assign unused_paddr_bits = ^{bus.paddr[ADDR_W-1:OFFSET_W], bus.paddr[1:0]};

  // A setup phase is only recognised from IDLE; psel+penable seen in IDLE
  // without a preceding setup is ignored.
  assign setup = (state == IDLE) && bus.psel && !bus.penable;

`ifdef APB_SLV_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (setup) begin
      cnt <= CNT_W'(WAIT_CYCLES);
    end else if (state == ACCESS && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign ready = (state == ACCESS) && (cnt == '0);
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign ready = (state == ACCESS);
`endif

  // Decode of the latched index; everything below depends only on state,
  // cnt and latched values, so the outputs never follow bus activity
  // during ACCESS.
  assign idx_ext = 32'(idx_q);
  assign bad_idx = idx_ext >= 32'(NUM_REGS);
  assign ro_wr   = wr_q && (idx_ext == 32'(NUM_REGS - 1));
  assign err     = bad_idx || ro_wr;
  assign commit  = ready && bus.psel && bus.penable;

  // --------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (setup) state_nxt = ACCESS;
      end
      ACCESS: begin
        // Dropping psel before completion aborts the transfer silently.
        if (!bus.psel)  state_nxt = IDLE;
        else if (commit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Setup-phase capture of direction, index and write data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (setup) begin
      wr_q    <= bus.pwrite;
      idx_q   <= bus.paddr[OFFSET_W-1:2];
      wdata_q <= bus.pwdata;
    end
  end

  // --------------------------------------------------------------------------
  // Register bank
  // --------------------------------------------------------------------------
  // NOTE: this bank is architecturally visible and must read 0 after reset,
  // so it is built from resettable flops rather than an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    end else if (commit && wr_q && !err) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (idx_ext == 32'(i)) regs[i] <= wdata_q;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (idx_ext == 32'(NUM_REGS - 1)) rd_val = ID_VAL;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx_ext == 32'(i)) rd_val = regs[i];
    end
  end

  // --------------------------------------------------------------------------
  // Response
  // --------------------------------------------------------------------------
  assign bus.pready  = ready;
  assign bus.pslverr = ready && err;
  assign bus.prdata  = (ready && !wr_q && !err) ? rd_val : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_slave
//   Self-checking bench for apb_reg_slave. The driver issues APB transfers and
//   pushes the response predicted by a register-map model into a scoreboard;
//   a monitor pops and compares on every completed transfer.
// ---------------------------------------------------------------------------
module tb_apb_reg_slave;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int WAIT_CYC = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int WAITS = WAIT_CYC;
`else
  localparam int WAITS = 0;
`endif
  localparam logic [31:0] ID_VAL = 32'hA5B0_0000 | 32'(NUM_REGS);

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  logic [31:0] mem [64];

  apb_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_reg_slave #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .OFFSET_W   (8),
    .NUM_REGS   (NUM_REGS),
    .WAIT_CYCLES(WAIT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register-map model: word index from paddr[7:2], 15 R/W words, one ID word.
  function automatic exp_t model(input bit wr, input logic [11:0] addr, input logic [31:0] d);
    exp_t e;
    int   idx;
    idx     = int'(addr[7:2]);
    e.is_rd = !wr;
    e.err   = 1'b0;
    e.data  = '0;
    if (idx >= NUM_REGS) begin
      e.err = 1'b1;
    end else if (idx == NUM_REGS - 1) begin
      if (wr) e.err = 1'b1;
      else    e.data = ID_VAL;
    end else if (wr) begin
      mem[idx] = d;
    end else begin
      e.data = mem[idx];
    end
    return e;
  endfunction

  // Monitor: every completed handshake must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && bus.psel && bus.penable && bus.pready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_completion: got pready=1 expected no transfer (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pslverr", {31'b0, bus.pslverr}, {31'b0, e.err});
        if (e.is_rd || e.err) check("prdata", bus.prdata, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] d);
    int n;
    bit done;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = d;
    sb.push_back(model(wr, addr, d));
    @(posedge clk); #1;
    bus.penable = 1'b1;
    // Request fields are latched at setup; scramble them during ACCESS.
    bus.paddr   = 12'($urandom);
    bus.pwdata  = $urandom;
    bus.pwrite  = 1'($urandom);
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.pready) done = 1'b1;
      else begin
        n++;
        if (n > 20) done = 1'b1;
      end
    end
    check("wait_states", 32'(n), 32'(WAITS));
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic abort_write(input logic [11:0] addr, input logic [31:0] d);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = addr;
    bus.pwdata  = d;
    @(posedge clk); #1;
    if (WAITS > 0) begin
      bus.penable = 1'b1;
      @(posedge clk); #1;
    end
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    rst         = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_pready",  {31'b0, bus.pready}, 32'h0);
    check("reset_prdata",  bus.prdata, 32'h0);
    check("reset_pslverr", {31'b0, bus.pslverr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Directed register-map cases.
    xfer(1'b1, 12'h304, 32'h0000_000D);
    xfer(1'b0, 12'h304, 32'h0);
    xfer(1'b0, 12'h03C, 32'h0);
    xfer(1'b1, 12'h03C, 32'h12);
    xfer(1'b0, 12'h03C, 32'h0);
    xfer(1'b0, 12'h080, 32'h0);
    xfer(1'b1, 12'h0FC, 32'h5555_AAAA);
    xfer(1'b0, 12'h0FC, 32'h0);
    xfer(1'b1, 12'h008, 32'h12);
    xfer(1'b0, 12'h008, 32'h0);
    xfer(1'b1, 12'h000, 32'hFFFF_FFFF);
    xfer(1'b1, 12'h038, 32'h8000_0001);
    xfer(1'b0, 12'h000, 32'h0);
    xfer(1'b0, 12'h038, 32'h0);

    // Abort leaves the register untouched.
    abort_write(12'h00C, 32'h9);
    xfer(1'b0, 12'h00C, 32'h0);

    // psel+penable without setup must not start a transfer.
    bus.psel    = 1'b1;
    bus.penable = 1'b1;
    bus.pwrite  = 1'b1;
    bus.paddr   = 12'h014;
    bus.pwdata  = 32'hDEAD_BEEF;
    idle(2);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    idle(1);
    xfer(1'b0, 12'h014, 32'h0);

    // Randomised traffic, mixed gaps and back-to-back transfers.
    for (int k = 0; k < 60; k++) begin
      logic [11:0] a;
      a = {4'($urandom), 6'($urandom_range(0, 19)), 2'($urandom)};
      xfer(1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    // Reset in the middle of a write's ACCESS phase.
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 12'h010;
    bus.pwdata  = 32'h6;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_pready",  {31'b0, bus.pready}, 32'h0);
    check("midrst_prdata",  bus.prdata, 32'h0);
    check("midrst_pslverr", {31'b0, bus.pslverr}, 32'h0);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    xfer(1'b0, 12'h010, 32'h0);
    xfer(1'b0, 12'h304, 32'h0);
    xfer(1'b0, 12'h03C, 32'h0);

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB completer: terminates one peripheral port of the 6-way APB interconnect (psel/addr/wr/data fan-out). Holds a bank of 32-bit registers and answers each setup/access transfer with pready, prdata and pslverr. Supports optional programmable wait states and error responses for bad offsets and read-only writes. One instance sits behind each interconnect psel line.

## Interface

Parameters:
- ADDR_W, 12, paddr width (matches interconnect address bus)
- DATA_W, 32, pwdata/prdata width
- OFFSET_W, 8, low paddr bits decoded locally; upper bits already decoded by the interconnect
- NUM_REGS, 16, register count; index NUM_REGS-1 is the read-only ID register
- WAIT_CYCLES, 2, wait states inserted per transfer (used only with APB_SLV_WAIT_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- psel  in  1  slave select from interconnect
- penable  in  1  access phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pready  out  1  transfer complete
- prdata  out  DATA_W  read data, valid only while pready=1
- pslverr  out  1  error response, valid only while pready=1

## Operation

- Index = paddr[OFFSET_W-1:2]; paddr[1:0] ignored; paddr[ADDR_W-1:OFFSET_W] ignored.
- Registers 0..NUM_REGS-2: read/write, reset 0.
- Register NUM_REGS-1: read-only ID, value 32'hA5B0_0000 | NUM_REGS (0xA5B0_0010 by default).
- FSM has 2 states:
  - IDLE: on psel=1, penable=0 (setup), latch pwrite, index and pwdata, load cnt <= wait count, go to ACCESS.
  - ACCESS: pready = (cnt==0). While cnt!=0, decrement cnt. When psel & penable & pready, complete the transfer and return to IDLE.
- Completion:
  - Write: commit the latched pwdata at the completing edge.
  - Read: prdata = register[index] while pready=1.
- Error, with pslverr=1 and pready=1:
  - index >= NUM_REGS: no write, prdata=0.
  - Write to the ID register: no write, prdata=0.
- Addr, data and dir are latched at setup. Changes during ACCESS are ignored.
- Abort: psel=0 in ACCESS before completion returns the FSM to IDLE, with no write and no response.
- psel=1 with penable=1 in IDLE (no setup seen) is ignored and the FSM stays in IDLE.

## Timing

- Reset values:
  - pready=0, prdata=0, pslverr=0
  - FSM=IDLE, cnt=0, all R/W registers 0
- Reset is asynchronous. Asserting it mid-transfer drops pready immediately and discards the pending write.
- Setup at cycle T0. With zero wait, pready=1 during T1 and the transfer completes at the end of T1.
- With WAIT_CYCLES=N, pready=1 during T1+N.
- pready, prdata and pslverr are combinational from state, cnt and the latched index. They are glitch-free relative to clk.
- Back-to-back transfers: the next setup is accepted in the cycle after completion, giving a minimum 2 cycles per transfer.
- Read-after-write to the same register returns the new value on the next transfer.

## Configuration

- APB_SLV_WAIT_EN defined:
  - Wait count = WAIT_CYCLES; cnt is WAIT_CYCLES-sized.
  - WAIT_CYCLES=0 is legal and gives zero-wait behaviour.
- Undefined:
  - No counter logic; pready=1 in the first ACCESS cycle.
  - WAIT_CYCLES is ignored.

## Test plan

- Reset, then write 0x0000000D to paddr 0x304 and read paddr 0x304 (macro off). Expect pready high in T1 of each transfer, prdata=0x0000000D, pslverr=0.
- Read paddr 0x03C. Expect prdata=0xA5B0_0010, pslverr=0. Then write 0x12 to 0x03C. Expect pslverr=1, and a re-read still returns 0xA5B0_0010.
- With NUM_REGS=8, read paddr 0x020. Expect pslverr=1 and prdata=0.
- APB_SLV_WAIT_EN with WAIT_CYCLES=2: write 0x12 to 0x008. Expect pready low for 2 ACCESS cycles, high on the 3rd, and the register updated only at completion.
- Abort: setup a write of 0x9 to 0x00C, then drop psel during the wait (macro on). Expect no pready, and a read of 0x00C returns the old value (0).
- Assert rst during the ACCESS of a write of 0x6 to 0x010. Expect all outputs 0 immediately, and a read after reset returns 0.
